// File: rtl/preg_alloc_arb.sv
// Physical-register allocation arbiter: round-robin grant of the free-list read port plus a
// commit-release FIFO, both held off during branch recovery. Stall statistic: PREG_ALLOC_ARB_STATS_EN.
module preg_alloc_arb #(
    parameter int NUM_REQ        = 2,
    parameter int PREG_W         = 7,
    parameter int FREE_DEPTH     = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PREG_W-1:0]  gnt_preg,
    input  logic               free_valid,
    input  logic [PREG_W-1:0]  free_preg,
    output logic               free_ready,
    input  logic               mispredict_in,
    output logic               fl_read_en,
    input  logic [PREG_W-1:0]  fl_pd_new,
    input  logic               fl_empty,
    output logic               fl_write_en,
    output logic [PREG_W-1:0]  fl_data_in,
    output logic               fl_mispredict,
    output logic [15:0]        stall_cnt,
    output logic               dbg_state
);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam int ADDR_W = $clog2(FREE_DEPTH);
    localparam logic [PTR_W:0]   NUM_REQ_V = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W+1)'(FREE_DEPTH);

    // Handshake: a release is taken on any rising edge where free_valid && free_ready;
    // the free-list ports are strobes qualified by fl_read_en / fl_write_en in the same cycle.
    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    state_t             state;
    logic [CNT_W-1:0]   rec_cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W:0]     cand;
    logic               found;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count;
    logic [PREG_W-1:0]  mem [FREE_DEPTH];
    logic               run_ok;
    logic               push;
    logic               pop;

    // Everything is gated by reset_n so outputs are quiet while reset is held.
    assign run_ok        = reset_n && (state == RUN) && !mispredict_in;
    assign fl_mispredict = mispredict_in;
    assign dbg_state     = (state == RECOVER);

    always_comb begin
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand >= NUM_REQ_V) cand = cand - NUM_REQ_V;
            if (!found && req[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[PTR_W-1:0];
            end
        end
        if (run_ok && !fl_empty && found) gnt[sel] = 1'b1;
    end

    assign fl_read_en = |gnt;
    assign gnt_preg   = fl_pd_new;

    assign free_ready  = (count != FULL_CNT);
    assign push        = free_valid && free_ready;
    assign pop         = run_ok && (count != '0);
    assign fl_write_en = pop;
    assign fl_data_in  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= free_preg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            rec_cnt <= '0;
            rr_ptr  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (mispredict_in) begin
                state   <= RECOVER;
                rec_cnt <= '0;
            end else if (state == RECOVER) begin
                if (rec_cnt == CNT_LAST) state <= RUN;
                else                     rec_cnt <= rec_cnt + 1'b1;
            end
            if (fl_read_en) rr_ptr <= (sel == LAST_LANE) ? '0 : sel + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef PREG_ALLOC_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if ((|req) && !(|gnt) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_preg_alloc_arb.sv
// Bench for preg_alloc_arb: directed scenarios plus random traffic, checked against a
// cycle-indexed queue model through an expected-response scoreboard.
module tb_preg_alloc_arb;
    localparam int NR = 2;
    localparam int PW = 7;
    localparam int FD = 4;
    localparam int RC = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt;
    logic [PW-1:0] gnt_preg;
    logic          free_valid = 1'b0;
    logic [PW-1:0] free_preg = '0;
    logic          free_ready;
    logic          mispredict_in = 1'b0;
    logic          fl_read_en;
    logic [PW-1:0] fl_pd_new = '0;
    logic          fl_empty = 1'b0;
    logic          fl_write_en;
    logic [PW-1:0] fl_data_in;
    logic          fl_mispredict;
    logic [15:0]   stall_cnt;
    logic          dbg_state;

    preg_alloc_arb #(.NUM_REQ(NR), .PREG_W(PW), .FREE_DEPTH(FD), .RECOVER_CYCLES(RC)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .gnt_preg(gnt_preg),
        .free_valid(free_valid), .free_preg(free_preg), .free_ready(free_ready),
        .mispredict_in(mispredict_in), .fl_read_en(fl_read_en), .fl_pd_new(fl_pd_new),
        .fl_empty(fl_empty), .fl_write_en(fl_write_en), .fl_data_in(fl_data_in),
        .fl_mispredict(fl_mispredict), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [NR-1:0] gnt;
        logic          rd;
        logic [PW-1:0] preg;
        logic          wen;
        logic [PW-1:0] data;
        logic          rdy;
        logic          mp;
        logic [15:0]   stall;
    } exp_t;

    exp_t exp_q[$];

    // Model: grants/releases are blocked on any cycle within RC cycles after a mispredict.
    int rr;
    int cyc;
    int block_until;
    int stall;
    int fq[$];

    task automatic model_reset();
        rr = 0;
        cyc = 0;
        block_until = -1;
        stall = 0;
        fq.delete();
    endtask

    task automatic drive_cycle(input logic [NR-1:0] r, input logic fv, input logic [PW-1:0] fp,
                               input logic mp, input logic fe, input logic [PW-1:0] pd);
        exp_t e;
        logic blocked;
        @(posedge clk);
        #1;
        req = r; free_valid = fv; free_preg = fp; mispredict_in = mp; fl_empty = fe; fl_pd_new = pd;
        e = '0;
        blocked = mp || (cyc <= block_until);
        e.mp = mp;
        if (!blocked && !fe && r != '0) begin
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (rr + i) % NR;
                if (r[k]) begin
                    e.gnt  = NR'(1) << k;
                    e.rd   = 1'b1;
                    e.preg = pd;
                    rr     = (k + 1) % NR;
                    break;
                end
            end
        end
        e.rdy = (fq.size() < FD);
        if (!blocked && fq.size() > 0) begin
            e.wen  = 1'b1;
            e.data = PW'(fq.pop_front());
        end
        if (fv && e.rdy) fq.push_back(int'(fp));
`ifdef PREG_ALLOC_ARB_STATS_EN
        e.stall = 16'(stall);
        if (r != '0 && e.gnt == '0 && stall < 65535) stall++;
`else
        e.stall = 16'd0;
`endif
        if (mp) block_until = cyc + RC;
        cyc++;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every presented cycle against the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt", gnt, e.gnt);
                check("fl_read_en", fl_read_en, e.rd);
                if (e.rd) check("gnt_preg", gnt_preg, e.preg);
                check("fl_write_en", fl_write_en, e.wen);
                if (e.wen) check("fl_data_in", fl_data_in, e.data);
                check("free_ready", free_ready, e.rdy);
                check("fl_mispredict", fl_mispredict, e.mp);
                check("stall_cnt", stall_cnt, e.stall);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        req = '1;
        mispredict_in = 1'b1;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_read_en", fl_read_en, 0);
        check("rst_write_en", fl_write_en, 0);
        check("rst_free_ready", free_ready, 1);
        check("rst_mispredict_follow", fl_mispredict, 1);
        check("rst_stall", stall_cnt, 0);
        req = '0;
        mispredict_in = 1'b0;
        reset_n = 1'b1;
        model_reset();

        // Alternating grants under constant two-lane request
        for (int i = 0; i < 4; i++) drive_cycle(2'b11, 1'b0, '0, 1'b0, 1'b0, PW'(i + 5));
        // Single-cycle mispredict pulse and recovery window
        drive_cycle(2'b01, 1'b0, '0, 1'b1, 1'b0, PW'(1));
        for (int i = 0; i < 3; i++) drive_cycle(2'b01, 1'b0, '0, 1'b0, 1'b0, PW'(i + 2));
        // Fill the release FIFO while recovering, then drain in order
        for (int i = 0; i < 5; i++) drive_cycle('0, 1'b1, PW'(40 + i), 1'b1, 1'b0, '0);
        for (int i = 0; i < 7; i++) drive_cycle('0, 1'b0, '0, 1'b0, 1'b0, '0);
        // Empty free list stalls a requester
        for (int i = 0; i < 3; i++) drive_cycle(2'b10, 1'b0, '0, 1'b0, 1'b1, '0);
        drive_cycle('0, 1'b0, '0, 1'b0, 1'b0, '0);

        // Reset mid-recovery with two buffered releases
        drive_cycle('0, 1'b1, PW'(10), 1'b1, 1'b0, '0);
        drive_cycle('0, 1'b1, PW'(11), 1'b0, 1'b0, '0);
        @(negedge clk);
        #2;
        check("pre_rst_recover", dbg_state, 1);
        req = '1; free_valid = 1'b0; mispredict_in = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_read_en", fl_read_en, 0);
        check("mid_rst_write_en", fl_write_en, 0);
        check("mid_rst_free_ready", free_ready, 1);
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_mispredict_follow", fl_mispredict, 0);
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) drive_cycle('0, 1'b0, '0, 1'b0, 1'b0, '0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive_cycle(NR'($urandom), ($urandom_range(1, 0) == 1), PW'($urandom),
                        ($urandom_range(15, 0) == 0), ($urandom_range(4, 0) == 0), PW'($urandom));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/preg_alloc_arb.md
PREG_ALLOC_ARB -- requirements
Module: preg_alloc_arb

Interface
- REQ-001: Parameter NUM_REQ, default 2, number of rename lanes requesting physical registers.
- REQ-002: Parameter PREG_W, default 7, physical register ID width.
- REQ-003: Parameter FREE_DEPTH, default 4, depth of the commit-free buffer (power of 2, >=2).
- REQ-004: Parameter RECOVER_CYCLES, default 2, cycles grants and frees are held after a mispredict (>=1).
- REQ-005: clk  in  1  single clock; all state changes on rising edge.
- REQ-006: reset_n  in  1  asynchronous, active-low reset.
- REQ-007: req  in  NUM_REQ  per-lane allocation request.
- REQ-008: gnt  out  NUM_REQ  one-hot grant, same cycle as req.
- REQ-009: gnt_preg  out  PREG_W  allocated register ID, valid when any gnt bit is set.
- REQ-010: free_valid / free_preg  in  1 / PREG_W  commit-side register release.
- REQ-011: free_ready  out  1  buffer can accept a release this cycle.
- REQ-012: mispredict_in  in  1  branch-recovery request (free-list snapshot restore).
- REQ-013: fl_read_en / fl_pd_new / fl_empty  out 1 / in PREG_W / in 1  free-list allocate port.
- REQ-014: fl_write_en / fl_data_in  out 1 / out PREG_W  free-list release port.
- REQ-015: fl_mispredict  out  1  restore strobe to the free list.
- REQ-016: stall_cnt  out  16  allocation-stall statistic (see Configuration).

Function
- REQ-017: FSM has states RUN and RECOVER; RUN -> RECOVER on mispredict_in; RECOVER -> RUN when the recovery counter reaches RECOVER_CYCLES-1 and mispredict_in is low.
- REQ-018: mispredict_in in either state reloads the recovery counter to 0 and keeps or enters RECOVER.
- REQ-019: fl_mispredict = mispredict_in, combinational, every cycle.
- REQ-020: In RUN with mispredict_in low and fl_empty low, exactly one requesting lane is granted, selected round-robin starting at rr_ptr.
- REQ-021: After a grant to lane k, rr_ptr becomes (k+1) mod NUM_REQ; otherwise rr_ptr holds.
- REQ-022: fl_read_en = OR of gnt; gnt_preg = fl_pd_new; zero-latency.
- REQ-023: No grant when in RECOVER, when mispredict_in is high, or when fl_empty is high; gnt = 0.
- REQ-024: Releases enter a FIFO of FREE_DEPTH entries; push when free_valid && free_ready; free_ready = FIFO not full.
- REQ-025: In RUN with mispredict_in low and FIFO non-empty, fl_write_en = 1, fl_data_in = FIFO head, head popped same edge; release-to-free-list latency >= 1 cycle.
- REQ-026: In RECOVER or with mispredict_in high, no pop; fl_write_en = 0; pushes still accepted while not full.
- REQ-027: Simultaneous push and pop on a non-full FIFO leaves occupancy unchanged; FIFO pointers wrap modulo FREE_DEPTH.
- REQ-028: Allocation and release in the same cycle are both performed.

Reset
- REQ-029: reset_n low asynchronously forces state RUN, recovery counter 0, rr_ptr 0, FIFO empty, stall_cnt 0.
- REQ-030: During reset gnt = 0, fl_read_en = 0, fl_write_en = 0, free_ready = 1; fl_mispredict still follows mispredict_in.
- REQ-031: Reset asserted mid-recovery or with FIFO occupied discards all pending state; no buffered release is emitted.

Configuration
- REQ-032: Macro PREG_ALLOC_ARB_STATS_EN: when defined, stall_cnt increments (saturating at 0xFFFF) each cycle where req != 0 and gnt == 0.
- REQ-033: When PREG_ALLOC_ARB_STATS_EN is undefined, stall_cnt is tied to 0 and no counter logic exists.

Verification
- REQ-034: req=2'b11 for 4 cycles, fl_empty=0 -> gnt = 01,10,01,10; fl_read_en=1 each cycle.
- REQ-035: mispredict_in pulsed 1 cycle, RECOVER_CYCLES=2, req=2'b01 -> fl_mispredict=1 that cycle; gnt=0 for that cycle + 2 following; grant resumes on 3rd cycle after.
- REQ-036: free_valid with preg 40,41,42,43,44 on back-to-back cycles while in RECOVER -> 40..43 accepted, free_ready=0 at 5th; after RUN, fl_data_in = 40,41,42,43 in order.
- REQ-037: fl_empty=1, req=2'b10 for 3 cycles -> gnt=0, fl_read_en=0; with STATS_EN, stall_cnt=3.
- REQ-038: reset_n dropped mid-RECOVER with 2 buffered releases -> outputs zero immediately; after release, free_ready=1, no fl_write_en, state RUN.
